// File: rtl/iot_pkg.sv
// ----------------------------------------------------------------------------
// iot_pkg
// Constants shared by the IoT event arbiter, the downstream active-device
// monitor and their benches.
//   N_DEV_DFLT  default number of IoT devices
//   PTR_W_DFLT  round-robin pointer width for the default device count
//   EVT_ON      event type code for a connect (monitor counts up)
//   EVT_OFF     event type code for a disconnect (monitor counts down)
//   FILT_CNT_W  width of the filtered-event statistics counter
//   sat_add     saturating add used by the statistics counter
// ----------------------------------------------------------------------------
package iot_pkg;

    localparam int   N_DEV_DFLT = 8;
    localparam int   PTR_W_DFLT = $clog2(N_DEV_DFLT);
    localparam logic EVT_ON     = 1'b1;
    localparam logic EVT_OFF    = 1'b0;
    localparam int   FILT_CNT_W = 8;

    // Adds two counter values and clamps at the all-ones maximum instead of
    // wrapping, so a busy system never makes the statistic look small.
    function automatic logic [FILT_CNT_W-1:0] sat_add(
        input logic [FILT_CNT_W-1:0] a,
        input logic [FILT_CNT_W-1:0] b
    );
        logic [FILT_CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[FILT_CNT_W] ? {FILT_CNT_W{1'b1}} : sum[FILT_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/iot_rr_arbiter.sv
// ----------------------------------------------------------------------------
// iot_rr_arbiter
// Purely combinational round-robin pick over a request vector. The search
// starts at rrPtr_i and wraps modulo N_DEV; the first set request wins.
// Ports:
//   pend_i       in   N_DEV  request (pending event) per device
//   rrPtr_i      in   PTR_W  device index the search starts at
//   gntOneHot_o  out  N_DEV  one-hot grant, zero when nothing is pending
//   gntIdx_o     out  PTR_W  index of the granted device (0 when no grant)
//   gntValid_o   out  1      a grant was made this cycle
// ----------------------------------------------------------------------------
module iot_rr_arbiter #(
    parameter int N_DEV = 8,
    parameter int PTR_W = 3
) (
    input  logic [N_DEV-1:0] pend_i,
    input  logic [PTR_W-1:0] rrPtr_i,
    output logic [N_DEV-1:0] gntOneHot_o,
    output logic [PTR_W-1:0] gntIdx_o,
    output logic             gntValid_o
);

    // Walk the devices in priority order starting at the pointer; once a
    // grant is found the later candidates are ignored.
    always_comb begin
        int idx;
        gntOneHot_o = '0;
        gntIdx_o    = '0;
        gntValid_o  = 1'b0;
        idx         = 0;
        for (int k = 0; k < N_DEV; k++) begin
            idx = (int'(rrPtr_i) + k) % N_DEV;
            if (!gntValid_o && pend_i[idx]) begin
                gntValid_o       = 1'b1;
                gntIdx_o         = PTR_W'(idx);
                gntOneHot_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iot_event_arbiter.sv
// ----------------------------------------------------------------------------
// iot_event_arbiter
// Upstream stage of the active-IoT-devices monitor. Collects per-device
// connect/disconnect pulses, drops redundant ones, and issues at most one
// accepted event per cycle in round-robin order. change/on_off drive the
// monitor counter directly, so that count always equals popcount(active_mask).
// Optional feature macro: IOT_EVT_STATS_EN adds the filt_count statistic.
// Ports:
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous active-high reset
//   dev_on       in   N_DEV  1-cycle pulse: device i reports connect
//   dev_off      in   N_DEV  1-cycle pulse: device i reports disconnect
//   change       out  1      1-cycle pulse, one accepted event issued
//   on_off       out  1      type of the issued event (1 = connect)
//   active_mask  out  N_DEV  devices currently counted as active downstream
//   pending_any  out  1      some event still waits to be issued
//   filt_count   out  8      saturating count of filtered events (stats only)
// ----------------------------------------------------------------------------
module iot_event_arbiter #(
    parameter int N_DEV = iot_pkg::N_DEV_DFLT,
    parameter int PTR_W = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_on,
    input  logic [N_DEV-1:0] dev_off,
    output logic             change,
    output logic             on_off,
    output logic [N_DEV-1:0] active_mask,
`ifdef IOT_EVT_STATS_EN
    output logic [iot_pkg::FILT_CNT_W-1:0] filt_count,
`endif
    output logic             pending_any
);

    import iot_pkg::*;

    logic [N_DEV-1:0] activeMask_q, activeMask_d;
    logic [N_DEV-1:0] pend_q, pend_d;
    logic [N_DEV-1:0] pendOn_q, pendOn_d;
    logic [PTR_W-1:0] rrPtr_q, rrPtr_d;
    logic             change_q, change_d;
    logic             onOff_q, onOff_d;
    logic             pendingAny_q;

    logic [N_DEV-1:0] gntOneHot;
    logic [PTR_W-1:0] gntIdx;
    logic             gntValid;

    logic [N_DEV-1:0] effState;
    logic [N_DEV-1:0] bothEvt;
    logic [N_DEV-1:0] validEvt;
    logic [N_DEV-1:0] dupEvt;
    logic [N_DEV-1:0] cancelEvt;

    iot_rr_arbiter #(
        .N_DEV (N_DEV),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .pend_i      (pend_q),
        .rrPtr_i     (rrPtr_q),
        .gntOneHot_o (gntOneHot),
        .gntIdx_o    (gntIdx),
        .gntValid_o  (gntValid)
    );

    // The state a device will reach once its waiting event is issued; new
    // pulses are judged against this, not against the downstream view.
    assign effState  = activeMask_q ^ pend_q;
    assign bothEvt   = dev_on & dev_off;
    assign validEvt  = (dev_on & ~dev_off & ~effState) | (dev_off & ~dev_on & effState);
    assign dupEvt    = (dev_on & ~dev_off & effState) | (dev_off & ~dev_on & ~effState);
    // A valid event on a device that already waits undoes the waiting one,
    // unless that waiting one is leaving this very cycle through the grant.
    assign cancelEvt = validEvt & pend_q & ~gntOneHot;

    // Issue the granted event and fold this cycle's accepted pulses into the
    // pending set. A granted device that also gets a new valid pulse keeps a
    // pending flag, now carrying the new type.
    always_comb begin
        activeMask_d = activeMask_q;
        pend_d       = pend_q & ~gntOneHot;
        pendOn_d     = pendOn_q;
        rrPtr_d      = rrPtr_q;
        change_d     = 1'b0;
        onOff_d      = onOff_q;
        if (gntValid) begin
            change_d             = 1'b1;
            onOff_d              = pendOn_q[gntIdx];
            activeMask_d[gntIdx] = pendOn_q[gntIdx];
            rrPtr_d              = (gntIdx == PTR_W'(N_DEV - 1)) ? '0 : gntIdx + PTR_W'(1);
        end
        for (int i = 0; i < N_DEV; i++) begin
            if (validEvt[i]) begin
                if (cancelEvt[i]) begin
                    pend_d[i] = 1'b0;
                end else begin
                    pend_d[i]   = 1'b1;
                    pendOn_d[i] = dev_on[i] ? EVT_ON : EVT_OFF;
                end
            end
        end
    end

    // Main state registers; reset discards every waiting event at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            activeMask_q <= '0;
            pend_q       <= '0;
            pendOn_q     <= '0;
            rrPtr_q      <= '0;
            change_q     <= 1'b0;
            onOff_q      <= 1'b0;
            pendingAny_q <= 1'b0;
        end else begin
            activeMask_q <= activeMask_d;
            pend_q       <= pend_d;
            pendOn_q     <= pendOn_d;
            rrPtr_q      <= rrPtr_d;
            change_q     <= change_d;
            onOff_q      <= onOff_d;
            pendingAny_q <= |pend_d;
        end
    end

    assign change      = change_q;
    assign on_off      = onOff_q;
    assign active_mask = activeMask_q;
    assign pending_any = pendingAny_q;

`ifdef IOT_EVT_STATS_EN
    logic [FILT_CNT_W-1:0] filtCount_q, filtCount_d;
    logic [FILT_CNT_W-1:0] filtInc;
    logic [N_DEV-1:0]      filtVec;

    // Every filtered decision this cycle adds one; a cancel counts once.
    assign filtVec = bothEvt | dupEvt | cancelEvt;

    // Sum this cycle's filtered events and add them with saturation.
    always_comb begin
        filtInc = '0;
        for (int i = 0; i < N_DEV; i++) begin
            filtInc = filtInc + {{(FILT_CNT_W-1){1'b0}}, filtVec[i]};
        end
        filtCount_d = sat_add(filtCount_q, filtInc);
    end

    // Statistic register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filtCount_q <= '0;
        end else begin
            filtCount_q <= filtCount_d;
        end
    end

    assign filt_count = filtCount_q;
`else
    // Filter classification only feeds the statistic; nothing to count here.
    logic unusedFilt;
    assign unusedFilt = ^{bothEvt, dupEvt};
`endif

endmodule
